// File: rtl/agu_seq_if.sv
// Instruction, control and memory-request bundle for agu_seq.
// The DUT binds to modport master; the environment binds to slave.
interface agu_seq_if #(
  parameter int PC_WIDTH   = 10,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();
  logic                  halt;
  logic                  en;
  logic [5:0]            func;
  logic [DATA_WIDTH-1:0] S1;
  logic [DATA_WIDTH-1:0] S2;
  // 8-bit immediate; "const" is a reserved word, so it is carried as imm
  logic [7:0]            imm;
  logic [PC_WIDTH-1:0]   pc;
  logic                  stall;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [DATA_WIDTH-1:0] loadc_data;
  logic                  loadc_valid;
  logic                  ras_overflow;
  logic                  ras_underflow;

  modport master (
    input  halt, en, func, S1, S2, imm, mem_req_ready,
    output pc, stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           loadc_data, loadc_valid, ras_overflow, ras_underflow
  );

  modport slave (
    output halt, en, func, S1, S2, imm, mem_req_ready,
    input  pc, stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           loadc_data, loadc_valid, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/agu_seq.sv
// Sequential address-generation unit: PC register, jumps/branches, LOAD/STORE request FSM.
// Define AGU_RAS_EN to build the return-address stack (CALL/RET and overflow/underflow flags).
module agu_seq #(
  parameter int PC_WIDTH     = 10,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 6,
  parameter int RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  agu_seq_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_nxt;
  logic [PC_WIDTH-1:0]   w_pc_inc;
  logic [PC_WIDTH-1:0]   w_offset;
  logic [PC_WIDTH-1:0]   w_pc_rel;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_taken;
  logic                  r_valid;
  logic                  r_we;
  logic                  w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_loadc_data;
  logic [DATA_WIDTH-1:0] w_loadc_data_nxt;
  logic                  r_loadc_valid;
  logic                  w_loadc_valid_nxt;

`ifdef AGU_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [CNT_W-1:0]    r_ras_cnt;
  logic [IDX_W-1:0]    w_top_idx;
  logic                w_ras_full;
  logic                w_ras_empty;
  logic                w_push;
  logic                w_pop;
  logic                r_ovf;
  logic                r_unf;
  logic                w_ovf_nxt;
  logic                w_unf_nxt;

  assign w_ras_full  = (r_ras_cnt == CNT_W'(RAS_DEPTH));
  assign w_ras_empty = (r_ras_cnt == CNT_W'(0));
  assign w_top_idx   = IDX_W'(r_ras_cnt - CNT_W'(1));
`endif

  assign w_stall  = (r_state == ST_REQ);
  assign w_accept = bus.en & ~bus.halt & ~w_stall;
  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign w_offset = {{(PC_WIDTH-OFFSET_WIDTH){bus.imm[OFFSET_WIDTH-1]}},
                     bus.imm[OFFSET_WIDTH-1:0]};
  assign w_pc_rel = r_pc + w_offset;

  // Branch condition from func[2:0]; codes 1xx never take
  always_comb begin
    w_taken = 1'b0;
    case (bus.func[2:0])
      3'b000:  w_taken = bus.S1[DATA_WIDTH-1];
      3'b001:  w_taken = ~bus.S1[DATA_WIDTH-1];
      3'b010:  w_taken = (bus.S1 == DATA_WIDTH'(0));
      3'b011:  w_taken = (bus.S1 != DATA_WIDTH'(0));
      default: w_taken = 1'b0;
    endcase
  end

  // Instruction decode, memory FSM next state and all register next values
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_we_nxt          = r_we;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_loadc_data_nxt  = r_loadc_data;
    w_loadc_valid_nxt = 1'b0;
`ifdef AGU_RAS_EN
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_nxt = r_ovf;
    w_unf_nxt = r_unf;
`endif
    case (r_state)
      ST_REQ: begin
        // valid is always high here, so ready alone completes the handshake
        if (bus.mem_req_ready) begin
          w_state_nxt = ST_IDLE;
          w_pc_nxt    = w_pc_inc;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          casez (bus.func)
            6'b000???: w_pc_nxt = bus.S1[PC_WIDTH-1:0];
            6'b001???: w_pc_nxt = w_pc_rel;
            6'b010???: w_pc_nxt = w_taken ? bus.S2[PC_WIDTH-1:0] : w_pc_inc;
            6'b011???: w_pc_nxt = w_taken ? w_pc_rel : w_pc_inc;
            6'b1000??, 6'b1001??: begin
              w_state_nxt = ST_REQ;
              w_we_nxt    = bus.func[2];
              w_addr_nxt  = bus.S1[ADDR_WIDTH-1:0];
              w_wdata_nxt = bus.S2;
            end
            6'b1010??: begin
              w_loadc_data_nxt  = {bus.S1[DATA_WIDTH-1:8], bus.imm};
              w_loadc_valid_nxt = 1'b1;
              w_pc_nxt          = w_pc_inc;
            end
`ifdef AGU_RAS_EN
            6'b101100: begin
              w_pc_nxt = bus.S1[PC_WIDTH-1:0];
              if (w_ras_full) begin
                w_ovf_nxt = 1'b1;
              end else begin
                w_push = 1'b1;
              end
            end
            6'b101101: begin
              if (w_ras_empty) begin
                w_pc_nxt  = w_pc_inc;
                w_unf_nxt = 1'b1;
              end else begin
                w_pc_nxt = r_ras[w_top_idx];
                w_pop    = 1'b1;
              end
            end
`endif
            default: w_pc_nxt = w_pc_inc;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, PC and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_valid       <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_loadc_data  <= '0;
      r_loadc_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_valid       <= (w_state_nxt == ST_REQ);
      r_we          <= w_we_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_loadc_data  <= w_loadc_data_nxt;
      r_loadc_valid <= w_loadc_valid_nxt;
    end
  end

`ifdef AGU_RAS_EN
  // Return-address stack storage, depth counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
      r_ras_cnt <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (w_push) begin
        r_ras[IDX_W'(r_ras_cnt)] <= w_pc_inc;
        r_ras_cnt                <= r_ras_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end else begin
        r_ras_cnt <= r_ras_cnt;
      end
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
    end
  end

  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;
`else
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  assign bus.pc            = r_pc;
  assign bus.stall         = w_stall;
  assign bus.mem_req_valid = r_valid;
  assign bus.mem_req_we    = r_we;
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.loadc_data    = r_loadc_data;
  assign bus.loadc_valid   = r_loadc_valid;

endmodule

// File: tb/tb_agu_seq.sv
// Self-checking bench for agu_seq: vector table for single-cycle ops, hand sequences for
// memory handshake, halt, return stack (build-dependent on AGU_RAS_EN) and reset.
module tb_agu_seq;
  localparam logic [5:0] F_JMP    = 6'b000000;
  localparam logic [5:0] F_JMPR   = 6'b001000;
  localparam logic [5:0] F_LOAD   = 6'b100000;
  localparam logic [5:0] F_STORE  = 6'b100100;
  localparam logic [5:0] F_LOADC  = 6'b101000;
  localparam logic [5:0] F_CALL   = 6'b101100;
  localparam logic [5:0] F_RET    = 6'b101101;

  logic clk;
  logic rst_n;
  agu_seq_if bus ();

  agu_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [9:0] pc;
  } sb_t;

  typedef struct {
    string       nm;
    logic        en;
    logic        halt;
    logic [5:0]  func;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [7:0]  imm;
    logic [9:0]  pc;
    logic        lv;
    logic [31:0] ld;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard: queue empty, got pc 0x%0h, expected an entry", bus.pc);
    end else begin
      e = sb_q.pop_front();
      chk(e.nm, 32'(bus.pc), 32'(e.pc));
    end
  endtask

  // drive one instruction at a negedge, check pc at the following negedge
  task automatic exec(input string nm, input logic e, input logic h, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b, input logic [7:0] k,
                      input logic [9:0] exp_pc);
    bus.en   = e;
    bus.halt = h;
    bus.func = f;
    bus.S1   = a;
    bus.S2   = b;
    bus.imm  = k;
    sb_q.push_back('{nm, exp_pc});
    @(negedge clk);
    bus.en   = 1'b0;
    bus.halt = 1'b0;
    pop_check();
  endtask

  task automatic add(input string nm, input logic e, input logic h, input logic [5:0] f,
                     input logic [31:0] a, input logic [31:0] b, input logic [7:0] k,
                     input logic [9:0] p, input logic lv, input logic [31:0] ld);
    vecs.push_back('{nm, e, h, f, a, b, k, p, lv, ld});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".pc"},     32'(bus.pc), 32'h0);
    chk({tag, ".stall"},  32'(bus.stall), 32'h0);
    chk({tag, ".valid"},  32'(bus.mem_req_valid), 32'h0);
    chk({tag, ".we"},     32'(bus.mem_req_we), 32'h0);
    chk({tag, ".addr"},   32'(bus.mem_req_addr), 32'h0);
    chk({tag, ".wdata"},  bus.mem_req_wdata, 32'h0);
    chk({tag, ".ldata"},  bus.loadc_data, 32'h0);
    chk({tag, ".lvalid"}, 32'(bus.loadc_valid), 32'h0);
    chk({tag, ".ovf"},    32'(bus.ras_overflow), 32'h0);
    chk({tag, ".unf"},    32'(bus.ras_underflow), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.halt = 1'b0; bus.func = 6'h0;
    bus.S1 = 32'h0; bus.S2 = 32'h0; bus.imm = 8'h0; bus.mem_req_ready = 1'b1;

    add("jmp_3fe",     1'b1, 1'b0, F_JMP,     32'h3FE,      32'h0,      8'h00, 10'h3FE, 1'b0, 32'h0);
    add("jmpr_wrap",   1'b1, 1'b0, F_JMPR,    32'h0,        32'h0,      8'h05, 10'h003, 1'b0, 32'h0);
    add("jmp_3fe_b",   1'b1, 1'b0, F_JMP,     32'h3FE,      32'h0,      8'h00, 10'h3FE, 1'b0, 32'h0);
    add("jmpr_neg1",   1'b1, 1'b0, F_JMPR,    32'h0,        32'h0,      8'h3F, 10'h3FD, 1'b0, 32'h0);
    add("jc_eq_take",  1'b1, 1'b0, 6'b010010, 32'h0,        32'h1234,   8'h00, 10'h234, 1'b0, 32'h0);
    add("jc_eq_not",   1'b1, 1'b0, 6'b010010, 32'h1,        32'h1234,   8'h00, 10'h235, 1'b0, 32'h0);
    add("jc_never",    1'b1, 1'b0, 6'b010100, 32'h0,        32'h1234,   8'h00, 10'h236, 1'b0, 32'h0);
    add("jc_neg_take", 1'b1, 1'b0, 6'b010000, 32'h80000000, 32'h050,    8'h00, 10'h050, 1'b0, 32'h0);
    add("jc_ge_not",   1'b1, 1'b0, 6'b010001, 32'h80000000, 32'h077,    8'h00, 10'h051, 1'b0, 32'h0);
    add("jc_ge_take",  1'b1, 1'b0, 6'b010001, 32'h5,        32'h077,    8'h00, 10'h077, 1'b0, 32'h0);
    add("jrc_ne_take", 1'b1, 1'b0, 6'b011011, 32'h7,        32'h0,      8'h02, 10'h079, 1'b0, 32'h0);
    add("jrc_eq_not",  1'b1, 1'b0, 6'b011010, 32'h3,        32'h0,      8'h02, 10'h07A, 1'b0, 32'h0);
    add("loadc",       1'b1, 1'b0, F_LOADC,   32'h12345678, 32'h0,      8'hAB, 10'h07B, 1'b1, 32'h123456AB);
    add("other_op",    1'b1, 1'b0, 6'b111111, 32'h0,        32'h0,      8'h00, 10'h07C, 1'b0, 32'h0);
    add("halt_hold",   1'b1, 1'b1, F_JMP,     32'h100,      32'h0,      8'h00, 10'h07C, 1'b0, 32'h0);
    add("en_low_hold", 1'b0, 1'b0, F_JMP,     32'h100,      32'h0,      8'h00, 10'h07C, 1'b0, 32'h0);

    #1;
    check_zero("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      exec(vecs[i].nm, vecs[i].en, vecs[i].halt, vecs[i].func, vecs[i].s1, vecs[i].s2,
           vecs[i].imm, vecs[i].pc);
      chk({vecs[i].nm, ".lvalid"}, 32'(bus.loadc_valid), 32'(vecs[i].lv));
      if (vecs[i].lv) chk({vecs[i].nm, ".ldata"}, bus.loadc_data, vecs[i].ld);
    end

    // STORE with ready low for two cycles
    exec("jmp_020", 1'b1, 1'b0, F_JMP, 32'h020, 32'h0, 8'h00, 10'h020);
    bus.mem_req_ready = 1'b0;
    exec("st_hold", 1'b1, 1'b0, F_STORE, 32'hABCD, 32'hDEADBEEF, 8'h00, 10'h020);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st_valid%0d", c), 32'(bus.mem_req_valid), 32'h1);
      chk($sformatf("st_stall%0d", c), 32'(bus.stall), 32'h1);
      chk($sformatf("st_we%0d", c),    32'(bus.mem_req_we), 32'h1);
      chk($sformatf("st_addr%0d", c),  32'(bus.mem_req_addr), 32'hABCD);
      chk($sformatf("st_wdata%0d", c), bus.mem_req_wdata, 32'hDEADBEEF);
      chk($sformatf("st_pc%0d", c),    32'(bus.pc), 32'h020);
      if (c == 2) bus.mem_req_ready = 1'b1;
      @(negedge clk);
    end
    chk("st_done_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("st_done_stall", 32'(bus.stall), 32'h0);
    chk("st_done_pc",    32'(bus.pc), 32'h021);

    // LOAD with ready tied high: two cycles accept-to-accept
    exec("ld_fast", 1'b1, 1'b0, F_LOAD, 32'h0042, 32'h0, 8'h00, 10'h021);
    chk("ld_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("ld_we",    32'(bus.mem_req_we), 32'h0);
    chk("ld_addr",  32'(bus.mem_req_addr), 32'h0042);
    @(negedge clk);
    chk("ld_done_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("ld_done_pc",    32'(bus.pc), 32'h022);

    // halt raised while a request is outstanding
    bus.mem_req_ready = 1'b0;
    exec("ld_halt", 1'b1, 1'b0, F_LOAD, 32'h0099, 32'h0, 8'h00, 10'h022);
    bus.halt = 1'b1; bus.en = 1'b1; bus.func = F_JMP; bus.S1 = 32'h3FF;
    @(negedge clk);
    chk("hl_valid", 32'(bus.mem_req_valid), 32'h1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("hl_done_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("hl_done_pc",    32'(bus.pc), 32'h023);
    @(negedge clk);
    chk("hl_hold_pc", 32'(bus.pc), 32'h023);
    @(negedge clk);
    chk("hl_hold_pc2", 32'(bus.pc), 32'h023);
    bus.halt = 1'b0; bus.en = 1'b0;

    // return-address stack: 5 CALLs into depth 4, then 5 RETs
    exec("jmp_010", 1'b1, 1'b0, F_JMP, 32'h010, 32'h0, 8'h00, 10'h010);
    for (int i = 0; i < 5; i++) begin
`ifdef AGU_RAS_EN
      exec($sformatf("call%0d", i), 1'b1, 1'b0, F_CALL, 32'h100, 32'h0, 8'h00, 10'h100);
      chk($sformatf("call%0d_ovf", i), 32'(bus.ras_overflow), (i == 4) ? 32'h1 : 32'h0);
`else
      exec($sformatf("call%0d", i), 1'b1, 1'b0, F_CALL, 32'h100, 32'h0, 8'h00, 10'(10'h011 + i));
      chk($sformatf("call%0d_ovf", i), 32'(bus.ras_overflow), 32'h0);
`endif
    end
    for (int i = 0; i < 5; i++) begin
`ifdef AGU_RAS_EN
      exec($sformatf("ret%0d", i), 1'b1, 1'b0, F_RET, 32'h0, 32'h0, 8'h00,
           (i < 3) ? 10'h101 : ((i == 3) ? 10'h011 : 10'h012));
      chk($sformatf("ret%0d_unf", i), 32'(bus.ras_underflow), (i == 4) ? 32'h1 : 32'h0);
`else
      exec($sformatf("ret%0d", i), 1'b1, 1'b0, F_RET, 32'h0, 32'h0, 8'h00, 10'(10'h016 + i));
      chk($sformatf("ret%0d_unf", i), 32'(bus.ras_underflow), 32'h0);
`endif
    end

    // reset while a STORE is outstanding at pc 0x155
    exec("jmp_155", 1'b1, 1'b0, F_JMP, 32'h155, 32'h0, 8'h00, 10'h155);
    exec("lc_pre", 1'b1, 1'b0, F_LOADC, 32'hCAFE0000, 32'h0, 8'h11, 10'h156);
    exec("jmp_155b", 1'b1, 1'b0, F_JMP, 32'h155, 32'h0, 8'h00, 10'h155);
    bus.mem_req_ready = 1'b0;
    exec("st_rst", 1'b1, 1'b0, F_STORE, 32'h5555, 32'h12345678, 8'h00, 10'h155);
    chk("pre_rst_valid", 32'(bus.mem_req_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;
    bus.mem_req_ready = 1'b1;
    exec("post_rst", 1'b0, 1'b0, F_JMP, 32'h0, 32'h0, 8'h00, 10'h000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
